// File: rtl/ft60x_pkg.sv
// Shared types and constants for the FT60x 245-mode bus scheduler.
package ft60x_pkg;

  localparam int FT_DATA_W = 32;
  localparam int FT_BE_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_OE,
    ST_RX_DATA,
    ST_TX_DATA,
    ST_TURN
  } ft_state_e;

endpackage

// File: rtl/ft60x_rr_arb.sv
// Two-requester round-robin arbiter; the pointer moves to the opposite side of each taken grant.
module ft60x_rr_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic req_rx,
  input  logic req_tx,
  input  logic advance,
  output logic gnt_rx,
  output logic gnt_tx
);

  // ptr_q = 0 prefers RX, 1 prefers TX
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_rx = req_rx & (~req_tx | ~ptr_q);
    gnt_tx = req_tx & (~req_rx | ptr_q);
    ptr_d  = ptr_q;
    if (advance) begin
      ptr_d = gnt_rx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ft60x_bus_sched.sv
// Half-duplex FT60x bus scheduler: turnaround-separated, length-bounded RX/TX bursts
// with round-robin fairness between the two directions.
module ft60x_bus_sched
  import ft60x_pkg::*;
#(
  parameter int MAX_BURST = 256,
  parameter int TURN_CYC  = 1,
  parameter int CNT_W     = 32
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 ftdi_rxf_n_i,
  input  logic                 ftdi_txe_n_i,
  input  logic [FT_DATA_W-1:0] ftdi_data_in_i,
  input  logic [FT_BE_W-1:0]   ftdi_be_in_i,
  output logic                 ftdi_oe_n_o,
  output logic                 ftdi_rd_n_o,
  output logic                 ftdi_wr_n_o,
  output logic [FT_DATA_W-1:0] ftdi_data_out_o,
  output logic [FT_BE_W-1:0]   ftdi_be_out_o,
  output logic                 ftdi_drive_o,
  input  logic [15:0]          rx_space_i,
  output logic                 rx_valid_o,
  output logic [FT_DATA_W-1:0] rx_data_o,
  output logic [FT_BE_W-1:0]   rx_be_o,
  input  logic                 tx_valid_i,
  input  logic [FT_DATA_W-1:0] tx_data_i,
  input  logic [FT_BE_W-1:0]   tx_be_i,
  output logic                 tx_ready_o,
  output logic [CNT_W-1:0]     rx_words_o,
  output logic [CNT_W-1:0]     tx_words_o,
  output logic                 busy_o
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

  ft_state_e        state_q, state_d;
  logic             oe_n_q, oe_n_d, rd_n_q, rd_n_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic [CNT_W-1:0] rx_words_q, rx_words_d, tx_words_q, tx_words_d;
  logic             in_idle, rx_elig, tx_elig, gnt_rx, gnt_tx;
  logic             rx_xfer, tx_xfer, burst_last;

  assign in_idle    = (state_q == ST_IDLE);
  assign rx_elig    = ~ftdi_rxf_n_i & (int'(rx_space_i) >= MAX_BURST);
  assign tx_elig    = ~ftdi_txe_n_i & tx_valid_i;
  assign rx_xfer    = (state_q == ST_RX_DATA) & ~rd_n_q & ~ftdi_rxf_n_i;
  assign tx_xfer    = (state_q == ST_TX_DATA) & tx_valid_i & ~ftdi_txe_n_i;
  assign burst_last = (bcnt_q == BW'(MAX_BURST - 1));

  ft60x_rr_arb u_arb (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .req_rx  (in_idle & rx_elig),
    .req_tx  (in_idle & tx_elig),
    .advance (in_idle & (gnt_rx | gnt_tx)),
    .gnt_rx  (gnt_rx),
    .gnt_tx  (gnt_tx)
  );

  always_comb begin
    state_d    = state_q;
    oe_n_d     = 1'b1;
    rd_n_d     = 1'b1;
    tcnt_d     = '0;
    bcnt_d     = (rx_xfer | tx_xfer) ? bcnt_q + BW'(1) : bcnt_q;
    rx_words_d = rx_xfer ? rx_words_q + CNT_W'(1) : rx_words_q;
    tx_words_d = tx_xfer ? tx_words_q + CNT_W'(1) : tx_words_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_rx) begin
          state_d = ST_RX_OE;
          oe_n_d  = 1'b0;
          bcnt_d  = '0;
        end else if (gnt_tx) begin
          state_d = ST_TX_DATA;
          bcnt_d  = '0;
        end
      end
      ST_RX_OE: begin
        state_d = ST_RX_DATA;
        oe_n_d  = 1'b0;
        rd_n_d  = 1'b0;
      end
      ST_RX_DATA: begin
        // strobes must already be high on the edge that leaves the burst
        if (ftdi_rxf_n_i | (rx_xfer & burst_last)) begin
          state_d = ST_TURN;
        end else begin
          oe_n_d = 1'b0;
          rd_n_d = 1'b0;
        end
      end
      ST_TX_DATA: begin
        if (ftdi_txe_n_i | ~tx_valid_i | (tx_xfer & burst_last)) begin
          state_d = ST_TURN;
        end
      end
      ST_TURN: begin
        if (tcnt_q == TW'(TURN_CYC - 1)) begin
          state_d = ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= ST_IDLE;
      oe_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      bcnt_q     <= '0;
      tcnt_q     <= '0;
      rx_words_q <= '0;
      tx_words_q <= '0;
    end else begin
      state_q    <= state_d;
      oe_n_q     <= oe_n_d;
      rd_n_q     <= rd_n_d;
      bcnt_q     <= bcnt_d;
      tcnt_q     <= tcnt_d;
      rx_words_q <= rx_words_d;
      tx_words_q <= tx_words_d;
    end
  end

  assign ftdi_oe_n_o     = oe_n_q;
  assign ftdi_rd_n_o     = rd_n_q;
  assign ftdi_drive_o    = (state_q == ST_TX_DATA);
  assign ftdi_wr_n_o     = ~(ftdi_drive_o & tx_valid_i);
  assign ftdi_data_out_o = ftdi_drive_o ? tx_data_i : '0;
  assign ftdi_be_out_o   = ftdi_drive_o ? tx_be_i : '0;
  assign rx_valid_o      = rx_xfer;
  assign rx_data_o       = rx_xfer ? ftdi_data_in_i : '0;
  assign rx_be_o         = rx_xfer ? ftdi_be_in_i : '0;
  assign tx_ready_o      = tx_xfer;
  assign rx_words_o      = rx_words_q;
  assign tx_words_o      = tx_words_q;
  assign busy_o          = ~in_idle;

  // OE_N low means the FT601 drives the pads, so the FPGA must never drive too
  a_dir_excl: assert property (@(posedge ACLK) disable iff (!ARESETn)
                               !(~ftdi_oe_n_o && ftdi_drive_o));

endmodule

// File: tb/tb_ft60x_bus_sched.sv
// Scoreboard bench: FT601 pin model and TX source feed the DUT; a negedge monitor
// checks every transferred word, burst shapes, turnaround and counters.
`timescale 1ns/1ps
module tb_ft60x_bus_sched;

  localparam int MB = 4;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        ftdi_rxf_n_i = 1'b1;
  logic        ftdi_txe_n_i = 1'b1;
  logic [31:0] ftdi_data_in_i = '0;
  logic [3:0]  ftdi_be_in_i = '0;
  logic [15:0] rx_space_i = 16'd1024;
  logic        tx_valid_i = 1'b0;
  logic [31:0] tx_data_i = '0;
  logic [3:0]  tx_be_i = '0;
  logic        ftdi_oe_n_o, ftdi_rd_n_o, ftdi_wr_n_o, ftdi_drive_o;
  logic [31:0] ftdi_data_out_o, rx_data_o;
  logic [3:0]  ftdi_be_out_o, rx_be_o;
  logic        rx_valid_o, tx_ready_o, busy_o;
  logic [31:0] rx_words_o, tx_words_o;

  ft60x_bus_sched #(.MAX_BURST(MB), .TURN_CYC(1), .CNT_W(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ftdi_rxf_n_i(ftdi_rxf_n_i), .ftdi_txe_n_i(ftdi_txe_n_i),
    .ftdi_data_in_i(ftdi_data_in_i), .ftdi_be_in_i(ftdi_be_in_i),
    .ftdi_oe_n_o(ftdi_oe_n_o), .ftdi_rd_n_o(ftdi_rd_n_o), .ftdi_wr_n_o(ftdi_wr_n_o),
    .ftdi_data_out_o(ftdi_data_out_o), .ftdi_be_out_o(ftdi_be_out_o),
    .ftdi_drive_o(ftdi_drive_o), .rx_space_i(rx_space_i),
    .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o), .rx_be_o(rx_be_o),
    .tx_valid_i(tx_valid_i), .tx_data_i(tx_data_i), .tx_be_i(tx_be_i),
    .tx_ready_o(tx_ready_o), .rx_words_o(rx_words_o), .tx_words_o(tx_words_o),
    .busy_o(busy_o)
  );

  always #5 ACLK = ~ACLK;

  logic [35:0] ft_rx[$];
  logic [35:0] tx_src[$];
  logic [35:0] exp_rx[$];
  logic [35:0] exp_tx[$];
  int          burst_log[$];
  int          exp_log[$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          rx_xfer_f = 1'b0, tx_xfer_f = 1'b0;
  bit          rx_gate = 1'b1, tx_gate = 1'b1, txe_off = 1'b1, rand_mode = 1'b0;
  int          txe_hold_at = -1, tx_done = 0;
  int          cnt_rx = 0, cnt_tx = 0, wr_low_cnt = 0, blen = 0;
  bit          oe_low_seen = 1'b0;
  bit          oe_p = 1'b1, oe_p2 = 1'b1, rd_p = 1'b1, drv_p = 1'b0;
  logic [35:0] mon_w;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FT601 pin model and TX word source, updated just after each rising edge
  initial begin
    forever begin
      @(posedge ACLK);
      #1;
      if (rx_xfer_f && ft_rx.size() > 0) void'(ft_rx.pop_front());
      if (tx_xfer_f && tx_src.size() > 0) begin
        void'(tx_src.pop_front());
        tx_done++;
      end
      if (rand_mode) begin
        rx_gate = ($urandom_range(0, 3) != 0);
        tx_gate = ($urandom_range(0, 5) != 0);
      end
      ftdi_rxf_n_i = !(ft_rx.size() > 0 && rx_gate);
      {ftdi_be_in_i, ftdi_data_in_i} = (ft_rx.size() > 0) ? ft_rx[0] : 36'h0;
      tx_valid_i = (tx_src.size() > 0) && tx_gate;
      {tx_be_i, tx_data_i} = (tx_src.size() > 0) ? tx_src[0] : 36'h0;
      ftdi_txe_n_i = txe_off || (tx_done == txe_hold_at) ||
                     (rand_mode && $urandom_range(0, 4) == 0);
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks bus protocol
  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        rx_xfer_f = 1'b0; tx_xfer_f = 1'b0;
        cnt_rx = 0; cnt_tx = 0; blen = 0;
        burst_log.delete();
        oe_p = 1'b1; oe_p2 = 1'b1; rd_p = 1'b1; drv_p = 1'b0;
        continue;
      end
      check("rx_words", 64'(rx_words_o), 64'(cnt_rx));
      check("tx_words", 64'(tx_words_o), 64'(cnt_tx));
      check("dir_excl", 64'(!ftdi_oe_n_o && ftdi_drive_o), 64'd0);
      if (rd_p && !ftdi_rd_n_o)
        check("oe_one_cycle_before_rd", 64'({oe_p2, oe_p}), 64'b10);
      if ((!oe_p && ftdi_oe_n_o) || (drv_p && !ftdi_drive_o)) begin
        burst_log.push_back((drv_p ? 200 : 100) + blen);
        check("burst_len_max", 64'(blen <= MB), 64'd1);
        check("turn_after_burst",
              64'({ftdi_oe_n_o, ftdi_rd_n_o, ftdi_wr_n_o, ftdi_drive_o, busy_o}), 64'b11101);
        blen = 0;
      end
      if (rx_valid_o) begin
        check("rx_exp_nonempty", 64'(exp_rx.size() > 0), 64'd1);
        if (exp_rx.size() > 0) begin
          mon_w = exp_rx.pop_front();
          check("rx_word", 64'({rx_be_o, rx_data_o}), 64'(mon_w));
        end
        check("rx_strobes", 64'({ftdi_oe_n_o, ftdi_rd_n_o}), 64'd0);
        cnt_rx++; blen++;
      end
      if (tx_ready_o) begin
        check("tx_exp_nonempty", 64'(exp_tx.size() > 0), 64'd1);
        if (exp_tx.size() > 0) begin
          mon_w = exp_tx.pop_front();
          check("tx_word", 64'({ftdi_be_out_o, ftdi_data_out_o}), 64'(mon_w));
        end
        check("tx_strobes", 64'({ftdi_wr_n_o, ftdi_drive_o, ftdi_txe_n_i}), 64'b010);
        cnt_tx++; blen++;
      end
      if (!ftdi_oe_n_o) oe_low_seen = 1'b1;
      if (!ftdi_wr_n_o) wr_low_cnt++;
      rx_xfer_f = rx_valid_o;
      tx_xfer_f = tx_ready_o;
      oe_p2 = oe_p; oe_p = ftdi_oe_n_o; rd_p = ftdi_rd_n_o; drv_p = ftdi_drive_o;
    end
  end

  task automatic load_rx(input int n);
    logic [35:0] w;
    for (int i = 0; i < n; i++) begin
      w = {4'($urandom), $urandom};
      ft_rx.push_back(w);
      exp_rx.push_back(w);
    end
  endtask

  task automatic load_tx(input int n);
    logic [35:0] w;
    for (int i = 0; i < n; i++) begin
      w = {4'($urandom), $urandom};
      tx_src.push_back(w);
      exp_tx.push_back(w);
    end
  endtask

  task automatic start(input int space);
    ARESETn = 1'b0;
    rx_space_i = 16'(space);
    @(posedge ACLK);
  endtask

  task automatic release_rst();
    @(posedge ACLK);
    #2;
    ARESETn = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_rx.size() > 0 || exp_tx.size() > 0 || busy_o) && n < budget) begin
      @(negedge ACLK);
      n++;
    end
    check({name, "_drain_in_budget"}, 64'(n < budget), 64'd1);
    repeat (3) @(negedge ACLK);
  endtask

  task automatic check_log(input string name);
    check({name, "_burst_count"}, 64'(burst_log.size()), 64'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < burst_log.size(); i++)
      check({name, "_burst_shape"}, 64'(burst_log[i]), 64'(exp_log[i]));
  endtask

  initial begin
    int n, tot_rx, tot_tx;

    // RX only, 10 words
    start(1024); txe_off = 1'b1; load_rx(10);
    @(negedge ACLK);
    check("reset_state", 64'({ftdi_oe_n_o, ftdi_rd_n_o, ftdi_wr_n_o, ftdi_drive_o,
                              rx_valid_o, tx_ready_o, busy_o}), 64'b1110000);
    check("reset_rx_words", 64'(rx_words_o), 64'd0);
    release_rst();
    wait_idle("s1", 400);
    exp_log = '{104, 104, 102}; check_log("s1");
    check("s1_rx_words", 64'(rx_words_o), 64'd10);
    check("s1_busy", 64'(busy_o), 64'd0);

    // TX only, 5 words
    start(1024); load_tx(5); txe_off = 1'b0;
    release_rst(); wr_low_cnt = 0; oe_low_seen = 1'b0;
    wait_idle("s2", 400);
    exp_log = '{204, 201}; check_log("s2");
    check("s2_tx_words", 64'(tx_words_o), 64'd5);
    check("s2_wr_low_cycles", 64'(wr_low_cnt), 64'd5);
    check("s2_oe_stayed_high", 64'(oe_low_seen), 64'd0);

    // both directions streaming: fair alternation
    start(1024); load_rx(12); load_tx(12); txe_off = 1'b0;
    release_rst();
    wait_idle("s3", 600);
    exp_log = '{104, 204, 104, 204, 104, 204}; check_log("s3");

    // TXE_N rises after the third word of a burst
    start(1024); load_tx(8); txe_off = 1'b0; txe_hold_at = tx_done + 3;
    release_rst();
    repeat (15) @(negedge ACLK);
    check("s4_words_before_stall", 64'(tx_words_o), 64'd3);
    check("s4_held_not_ready", 64'(tx_ready_o), 64'd0);
    check("s4_words_pending", 64'(exp_tx.size()), 64'd5);
    txe_hold_at = -1;
    wait_idle("s4", 400);
    exp_log = '{203, 204, 201}; check_log("s4");

    // rx_space below one burst blocks RX
    start(MB - 1); txe_off = 1'b1; load_rx(3);
    release_rst(); oe_low_seen = 1'b0;
    repeat (20) @(negedge ACLK);
    check("s5_no_grant_oe", 64'(oe_low_seen), 64'd0);
    check("s5_not_busy", 64'(busy_o), 64'd0);
    @(posedge ACLK); #2; rx_space_i = 16'(MB);
    @(posedge ACLK); @(negedge ACLK);
    check("s5_oe_after_space", 64'({ftdi_oe_n_o, busy_o}), 64'b01);
    wait_idle("s5", 400);
    exp_log = '{103}; check_log("s5");

    // asynchronous reset during the second word of an RX burst
    start(1024); txe_off = 1'b1; load_rx(6);
    release_rst();
    n = 0;
    while (!rx_valid_o && n < 50) begin @(negedge ACLK); n++; end
    check("s6_first_word_seen", 64'(n < 50), 64'd1);
    @(posedge ACLK); #2;
    check("s6_in_rx_data", 64'({ftdi_oe_n_o, ftdi_rd_n_o, rx_valid_o}), 64'b001);
    ARESETn = 1'b0;
    #1;
    check("s6_reset_strobes", 64'({ftdi_oe_n_o, ftdi_rd_n_o, ftdi_wr_n_o, ftdi_drive_o,
                                   rx_valid_o, tx_ready_o, busy_o}), 64'b1110000);
    check("s6_reset_counters", 64'({rx_words_o, tx_words_o}), 64'd0);
    repeat (2) @(posedge ACLK);
    #2; ARESETn = 1'b1;
    wait_idle("s6", 400);
    exp_log = '{104, 101}; check_log("s6");
    check("s6_rx_words", 64'(rx_words_o), 64'd5);

    // randomized traffic, pin jitter and rx_space changes
    start(1024); txe_off = 1'b0; rand_mode = 1'b1;
    release_rst();
    tot_rx = 0; tot_tx = 0;
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(0, 7); load_rx(n); tot_rx += n;
      n = $urandom_range(0, 7); load_tx(n); tot_tx += n;
      rx_space_i = 16'($urandom_range(MB - 2, MB + 2));
      repeat ($urandom_range(4, 20)) @(negedge ACLK);
    end
    rand_mode = 1'b0; rx_gate = 1'b1; tx_gate = 1'b1; rx_space_i = 16'd1024;
    wait_idle("s7", 5000);
    check("s7_rx_total", 64'(rx_words_o), 64'(tot_rx));
    check("s7_tx_total", 64'(tx_words_o), 64'(tot_tx));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/ft60x_bus_sched.md
Name: ft60x_bus_sched

Overview:
- Half-duplex bus scheduler for the FT60x 245-mode synchronous FIFO bus. Clocked by the FT601-supplied clock, which also drives ACLK.
- Shares the single 32-bit bidirectional data bus between the host-to-FPGA RX stream and the FPGA-to-host TX stream.
- Generates OE_N, RD_N and WR_N with bus turnaround, bounded bursts and round-robin fairness.
- Sits between the FT601 pins and the bridge's RX/TX word streams, replacing ad-hoc pin sequencing in ft60x_axi.

Parameters:
- MAX_BURST, 256: maximum words per RX or TX burst before the bus is re-arbitrated.
- TURN_CYC, 1: idle cycles with all strobes high and the bus undriven, inserted after every burst.
- CNT_W, 32: width of the transferred-word statistics counters.

Ports:
- ACLK  in  1  FT601 clock; all logic on its rising edge.
- ARESETn  in  1  Asynchronous active-low reset.
- ftdi_rxf_n_i  in  1  RXF_N; low means the FT601 holds RX data.
- ftdi_txe_n_i  in  1  TXE_N; low means the FT601 has TX space.
- ftdi_data_in_i  in  32  DATA pad input.
- ftdi_be_in_i  in  4  BE pad input.
- ftdi_oe_n_o  out  1  OE_N.
- ftdi_rd_n_o  out  1  RD_N.
- ftdi_wr_n_o  out  1  WR_N.
- ftdi_data_out_o  out  32  DATA pad output.
- ftdi_be_out_o  out  4  BE pad output.
- ftdi_drive_o  out  1  Tristate enable for DATA/BE pads; 1 = FPGA drives.
- rx_space_i  in  16  Free words in the downstream RX buffer.
- rx_valid_o  out  1  RX word strobe; no backpressure.
- rx_data_o  out  32  RX word.
- rx_be_o  out  4  RX byte enables.
- tx_valid_i  in  1  TX word available.
- tx_data_i  in  32  TX word.
- tx_be_i  in  4  TX byte enables.
- tx_ready_o  out  1  TX word consumed this cycle.
- rx_words_o  out  CNT_W  Total RX words transferred.
- tx_words_o  out  CNT_W  Total TX words transferred.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (asynchronous):
  - OE_N, RD_N and WR_N = 1; ftdi_drive_o = 0.
  - Data/BE outputs = 0; rx_valid_o = 0; tx_ready_o = 0.
  - Counters = 0; FSM = IDLE; round-robin pointer = RX-preferred.
- Eligibility:
  - RX eligible when ftdi_rxf_n_i = 0 and rx_space_i >= MAX_BURST.
  - TX eligible when ftdi_txe_n_i = 0 and tx_valid_i = 1.
- Arbitration in IDLE:
  - Exactly one requester eligible: grant it.
  - Both eligible: grant the side the pointer selects. The pointer flips to the other side after every granted burst.
- FSM states: IDLE, RX_OE, RX_DATA, TX_DATA, TURN.
- IDLE -> RX_OE on an RX grant:
  - OE_N = 0 (registered); ftdi_drive_o = 0.
  - Stay one cycle, then -> RX_DATA.
- RX_DATA:
  - OE_N = 0 and RD_N = 0, both registered.
  - A word transfers on every edge with RD_N = 0 and ftdi_rxf_n_i = 0.
  - rx_valid_o = 1 on that cycle; rx_data_o/rx_be_o are the pad inputs passed through combinationally.
  - Exit to TURN when ftdi_rxf_n_i = 1 or the burst count reaches MAX_BURST. OE_N and RD_N return to 1 on the same edge.
- IDLE -> TX_DATA on a TX grant:
  - ftdi_drive_o = 1.
  - ftdi_wr_n_o = ~tx_valid_i (combinational while in TX_DATA).
  - tx_ready_o = tx_valid_i & ~ftdi_txe_n_i; data/BE outputs = tx_data_i/tx_be_i.
  - A word transfers when tx_ready_o = 1.
  - Exit to TURN when ftdi_txe_n_i = 1, tx_valid_i = 0, or the burst count reaches MAX_BURST. A word is never consumed while TXE_N = 1.
- TURN: all strobes high, ftdi_drive_o = 0 for TURN_CYC cycles, then -> IDLE. No back-to-back burst skips TURN.
- Burst counter: width clog2(MAX_BURST+1); cleared on entry to RX_OE or TX_DATA.
- rx_words_o/tx_words_o increment once per transferred word and wrap modulo 2^CNT_W.
- Direction exclusivity: OE_N = 0 and ftdi_drive_o = 1 are never true in the same cycle; a mismatch is an assertion failure.
- Reset mid-burst: all strobes deasserted immediately (asynchronous); the partial burst is dropped without replay.
- rx_space_i changing mid-burst is ignored; it is checked only at grant.

Decomposition:
- Shared package ft60x_pkg holds:
  - The FSM state enum.
  - Constants FT_DATA_W = 32 and FT_BE_W = 4.
- One sub-module, ft60x_rr_arb: two-requester round-robin arbiter holding the pointer. Inputs req_rx, req_tx, advance; outputs gnt_rx, gnt_tx.

Test Plan:
- RX only: FT601 model holds 10 words, TXE_N = 1, rx_space_i = 1024 -> OE_N falls one cycle before RD_N; exactly 10 rx_valid_o pulses, data in order; rx_words_o = 10; TURN seen; busy_o = 0.
- TX only: TX queue of 5 words, RXF_N = 1 -> 5 WR_N-low cycles with ftdi_drive_o = 1, matching data; tx_words_o = 5; OE_N stays 1 throughout.
- Both streaming, MAX_BURST = 4, 12 words each side -> bursts alternate RX, TX, RX, TX, RX, TX; each burst is 4 words; each is followed by 1 TURN cycle.
- TXE_N rises after word 3 of an 8-word TX burst -> exactly 3 words consumed; the 4th is held (tx_ready_o = 0) until the next TX grant; no data lost.
- rx_space_i = MAX_BURST-1 with RXF_N = 0 -> no RX grant and OE_N stays 1; raising rx_space_i to MAX_BURST starts RX_OE on the next cycle.
- ARESETn pulsed low during RX_DATA word 2 -> strobes high and ftdi_drive_o = 0 within the reset cycle; counters read 0; a clean RX burst follows after release.
